apb_reg_file: RTL and testbench
===============================

APB_REG_FILE -- requirements
Module: apb_reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32: request address width in bits.
REQ-003 Parameter NUM_REGS, default 16: number of word registers, power of two, range 2..256.
REQ-004 Parameter WAIT_STATES, default 1: wait cycles inserted before each response, range 0..15.
REQ-005 PCLK  input  1: clock; all state changes on its rising edge.
REQ-006 PRESETn  input  1: reset, asynchronous, active-low.
REQ-007 RegADDR  input  ADDR_WIDTH: byte address of the request.
REQ-008 RegWDATA  input  DATA_WIDTH: write data.
REQ-009 RegSTRB  input  DATA_WIDTH/8: write byte-lane enables; ignored on reads.
REQ-010 RegENABLE  input  1: request valid.
REQ-011 RegWRITE  input  1: 1 = write, 0 = read.
REQ-012 RegRDATA  output  DATA_WIDTH: read data, registered.
REQ-013 RegREADY  output  1: response strobe, registered.
REQ-014 RegSLVERR  output  1: error flag, registered, valid only with RegREADY.

Function
REQ-015 FSM states SHALL be RF_IDLE, RF_WAIT and RF_RESP.
REQ-016 In RF_IDLE with RegENABLE=1, the block SHALL latch RegADDR, RegWRITE, RegWDATA and RegSTRB, and load the wait counter with WAIT_STATES.
REQ-017 The accept edge SHALL move the FSM to RF_WAIT if WAIT_STATES>0; otherwise it SHALL move to RF_RESP.
REQ-018 In RF_WAIT the counter SHALL decrement on every edge, and the FSM SHALL move to RF_RESP on the edge where the count equals 1.
REQ-019 Request inputs SHALL be ignored outside RF_IDLE.
REQ-020 RF_RESP SHALL last exactly one cycle and SHALL always return to RF_IDLE.
REQ-021 RegREADY SHALL be 1 only during RF_RESP.
REQ-022 For an accept on edge k, RegREADY SHALL be high in the cycle following edge k+WAIT_STATES.
REQ-023 RegENABLE still high in the RF_IDLE cycle after RF_RESP SHALL be accepted as a new request (back-to-back).
REQ-024 Register index SHALL be RegADDR[log2(NUM_REGS)+1:2].
REQ-025 A request SHALL be an error if RegADDR[1:0]!=0, if RegADDR>=NUM_REGS*4, or if it is a write to index 0.
REQ-026 Index 0 SHALL be a read-only identification register returning the constant REG_ID.
REQ-027 A non-error write SHALL update, on the edge entering RF_RESP, each byte lane whose RegSTRB bit is 1; lanes with RegSTRB=0 SHALL keep their value.
REQ-028 An error write SHALL modify no register.
REQ-029 A non-error read SHALL present the indexed register on RegRDATA during RF_RESP.
REQ-030 RegRDATA SHALL be 0 outside RF_RESP, on writes, and on error responses.
REQ-031 RegSLVERR SHALL be 1 during RF_RESP for an error request and 0 at all other times.

Reset
REQ-032 While PRESETn=0 the FSM SHALL be in RF_IDLE, the wait counter SHALL be 0, and RegREADY, RegSLVERR and RegRDATA SHALL be 0.
REQ-033 While PRESETn=0 every register of index 1..NUM_REGS-1 SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer: no response is issued and no pending write is committed.
REQ-035 After reset release, the first rising edge with RegENABLE=1 SHALL be accepted as a new request.

Structure
REQ-036 The regfile_state_e enum (RF_IDLE, RF_WAIT, RF_RESP) and the constant REG_ID = 32'hA9B0_0001 SHALL reside in shared_pkg.
REQ-037 The RF_ prefix SHALL keep these names distinct from the existing state_e names.
REQ-038 The block SHALL be a single module with no sub-module; the register array, wait counter and FSM SHALL be inline.

Verification (WAIT_STATES=2, NUM_REGS=16)
REQ-039 Write 0x4 with data 0xDEADBEEF and RegSTRB=0xF, accepted at edge k -> RegREADY=1 only in the cycle after edge k+2, with RegSLVERR=0.
REQ-040 Read 0x4 -> RegRDATA=0xDEADBEEF with RegREADY=1 and RegSLVERR=0; RegRDATA=0 in the cycles before and after.
REQ-041 Write 0x4 with data 0x11223344 and RegSTRB=0x5, then read 0x4 -> RegRDATA=0xDE22BE44.
REQ-042 Read 0x0 -> RegRDATA=0xA9B00001; write 0x0 -> RegSLVERR=1; a subsequent read of 0x0 still returns 0xA9B00001.
REQ-043 Read 0x40 and read 0x6 -> RegSLVERR=1 and RegRDATA=0 for each; no register changes.
REQ-044 PRESETn pulsed low during RF_WAIT of a write 0x8 with data 0x55 -> no RegREADY pulse; a subsequent read of 0x8 returns 0.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared definitions for the register-file slice: FSM state encoding and
// the identification word returned from index 0.
package shared_pkg;

   typedef enum logic [1:0] {
      RF_IDLE = 2'd0,
      RF_WAIT = 2'd1,
      RF_RESP = 2'd2
   } regfile_state_e;

   localparam logic [31:0] REG_ID = 32'hA9B0_0001;

endpackage : shared_pkg

// File: rtl/apb_reg_file.sv
// Word-addressed register file behind a simple request/ready handshake with
// a fixed number of wait states. Index 0 is a read-only identification word.
module apb_reg_file
   import shared_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic [ADDR_WIDTH-1:0]   RegADDR,
   input  logic [DATA_WIDTH-1:0]   RegWDATA,
   input  logic [DATA_WIDTH/8-1:0] RegSTRB,
   input  logic                    RegENABLE,
   input  logic                    RegWRITE,
   output logic [DATA_WIDTH-1:0]   RegRDATA,
   output logic                    RegREADY,
   output logic                    RegSLVERR
);

   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

   regfile_state_e          state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       strb_q, strb_d;
   logic                    ready_q, ready_d;
   logic                    slverr_q, slverr_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0]   regs_d [1:NUM_REGS-1];

   logic [IDX_W-1:0]        req_idx_s;
   logic                    req_err_s;
   logic                    enter_resp_s;
   logic                    commit_s;
   logic [DATA_WIDTH-1:0]   rd_val_s;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_val,
      input logic [DATA_WIDTH-1:0] new_val,
      input logic [STRB_W-1:0]     strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_val;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_val[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_val[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // Next-state, request capture and wait counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      case (state_q)
         RF_IDLE: begin
            if (RegENABLE) begin
               addr_d  = RegADDR;
               write_d = RegWRITE;
               wdata_d = RegWDATA;
               strb_d  = RegSTRB;
               cnt_d   = 4'(WAIT_STATES);
               state_d = (WAIT_STATES > 0) ? RF_WAIT : RF_RESP;
            end else begin
               state_d = RF_IDLE;
            end
         end
         RF_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RF_RESP;
            end else begin
               state_d = RF_WAIT;
            end
         end
         RF_RESP: begin
            state_d = RF_IDLE;
         end
         default: begin
            state_d = RF_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Decode uses the *_d view so a zero-wait request is judged on the accept edge.
   always_comb begin
      req_idx_s    = addr_d[IDX_W+1:2];
      req_err_s    = (addr_d[1:0] != 2'b00) || (addr_d >= ADDR_LIMIT) ||
                     (write_d && (req_idx_s == '0));
      enter_resp_s = (state_d == RF_RESP);
      commit_s     = enter_resp_s && write_d && !req_err_s;
   end

   // Read mux: index 0 falls through to the identification word.
   always_comb begin
      rd_val_s = DATA_WIDTH'(REG_ID);
      for (int i = 1; i < NUM_REGS; i++) begin
         if (req_idx_s == IDX_W'(i)) begin
            rd_val_s = regs_q[i];
         end else begin
            rd_val_s = rd_val_s;
         end
      end
   end

   // Response outputs, computed for the cycle after this edge.
   always_comb begin
      ready_d  = enter_resp_s;
      slverr_d = enter_resp_s && req_err_s;
      if (enter_resp_s && !req_err_s && !write_d) begin
         rdata_d = rd_val_s;
      end else begin
         rdata_d = '0;
      end
   end

   // Register array next value with per-lane write merge.
   always_comb begin
      for (int i = 1; i < NUM_REGS; i++) begin
         if (commit_s && (req_idx_s == IDX_W'(i))) begin
            regs_d[i] = merge_lanes(regs_q[i], wdata_d, strb_d);
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // FSM, request latches and registered response outputs.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= RF_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         ready_q  <= 1'b0;
         slverr_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         ready_q  <= ready_d;
         slverr_q <= slverr_d;
         rdata_q  <= rdata_d;
      end
   end

   // Register storage; a reset mid-transfer drops any uncommitted write.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign RegRDATA  = rdata_q;
   assign RegREADY  = ready_q;
   assign RegSLVERR = slverr_q;

endmodule : apb_reg_file

// File: tb/tb_apb_reg_file.sv
// Self-checking bench for apb_reg_file (WAIT_STATES=2, NUM_REGS=16): directed
// vector table, hand-written timing sequences and a randomized model comparison.
module tb_apb_reg_file;

   logic        PCLK;
   logic        PRESETn;
   logic [31:0] RegADDR;
   logic [31:0] RegWDATA;
   logic [3:0]  RegSTRB;
   logic        RegENABLE;
   logic        RegWRITE;
   logic [31:0] RegRDATA;
   logic        RegREADY;
   logic        RegSLVERR;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [14];
   logic [31:0] mdl [16];

   apb_reg_file #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .NUM_REGS   (16),
      .WAIT_STATES(2)
   ) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .RegADDR  (RegADDR),
      .RegWDATA (RegWDATA),
      .RegSTRB  (RegSTRB),
      .RegENABLE(RegENABLE),
      .RegWRITE (RegWRITE),
      .RegRDATA (RegRDATA),
      .RegREADY (RegREADY),
      .RegSLVERR(RegSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; one request, then four observed cycles. Inputs are
   // scrambled while busy, which the block must ignore.
   task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [3:0] rdy, output logic [3:0] err,
                      output logic [31:0] rd, output logic other_nz);
      RegADDR   = a;
      RegWRITE  = w;
      RegWDATA  = d;
      RegSTRB   = s;
      RegENABLE = 1'b1;
      @(posedge PCLK);
      #1;
      RegENABLE = 1'b0;
      RegADDR   = $urandom;
      RegWDATA  = $urandom;
      RegSTRB   = 4'($urandom);
      RegWRITE  = 1'($urandom);
      other_nz  = 1'b0;
      rd        = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         rdy[i] = RegREADY;
         err[i] = RegSLVERR;
         if (i == 2) begin
            rd = RegRDATA;
         end else if (RegRDATA !== 32'h0) begin
            other_nz = 1'b1;
         end
      end
   endtask

   initial begin
      logic [3:0]  rdy, err;
      logic [31:0] rd, rd0, rd1, exp_rd, a, wd;
      logic        oth, w, exp_err, seen_ready;
      logic [3:0]  s;
      logic [7:0]  pat;
      int          idx, sel;

      vecs[0]  = '{32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
      vecs[1]  = '{32'h04, 1'b0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{32'h04, 1'b1, 32'h11223344, 4'h5, 1'b0, 32'h0};
      vecs[3]  = '{32'h04, 1'b0, 32'h0,        4'hF, 1'b0, 32'hDE22BE44};
      vecs[4]  = '{32'h00, 1'b0, 32'h0,        4'h0, 1'b0, 32'hA9B00001};
      vecs[5]  = '{32'h00, 1'b1, 32'h12345678, 4'hF, 1'b1, 32'h0};
      vecs[6]  = '{32'h00, 1'b0, 32'h0,        4'h0, 1'b0, 32'hA9B00001};
      vecs[7]  = '{32'h40, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0};
      vecs[8]  = '{32'h06, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0};
      vecs[9]  = '{32'h04, 1'b0, 32'h0,        4'h0, 1'b0, 32'hDE22BE44};
      vecs[10] = '{32'h3C, 1'b1, 32'hFFFFFFFF, 4'h8, 1'b0, 32'h0};
      vecs[11] = '{32'h3E, 1'b1, 32'h00000000, 4'hF, 1'b1, 32'h0};
      vecs[12] = '{32'h3C, 1'b0, 32'h0,        4'h0, 1'b0, 32'hFF000000};
      vecs[13] = '{32'h08, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0};

      PRESETn   = 1'b0;
      RegADDR   = 32'h0;
      RegWDATA  = 32'h0;
      RegSTRB   = 4'h0;
      RegENABLE = 1'b1;
      RegWRITE  = 1'b1;
      repeat (3) @(negedge PCLK);
      check("reset ready", {31'd0, RegREADY}, 32'h0);
      check("reset slverr", {31'd0, RegSLVERR}, 32'h0);
      check("reset rdata", RegRDATA, 32'h0);
      RegENABLE = 1'b0;
      PRESETn   = 1'b1;
      @(negedge PCLK);

      // Directed table
      for (int i = 0; i < 14; i++) begin
         txn(vecs[i].addr, vecs[i].write, vecs[i].wdata, vecs[i].strb, rdy, err, rd, oth);
         check($sformatf("vec%0d ready", i), {28'd0, rdy}, 32'h4);
         check($sformatf("vec%0d slverr", i), {28'd0, err}, vecs[i].exp_err ? 32'h4 : 32'h0);
         check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d rdata_idle", i), {31'd0, oth}, 32'h0);
      end

      // Back-to-back: RegENABLE held high, address changed while busy
      RegADDR   = 32'h04;
      RegWRITE  = 1'b0;
      RegSTRB   = 4'h0;
      RegENABLE = 1'b1;
      @(posedge PCLK);
      #1;
      RegADDR = 32'h3C;
      rd0 = 32'h0;
      rd1 = 32'h0;
      for (int j = 0; j < 8; j++) begin
         @(negedge PCLK);
         pat[j] = RegREADY;
         if (j == 2) rd0 = RegRDATA;
         if (j == 6) rd1 = RegRDATA;
      end
      RegENABLE = 1'b0;
      check("b2b ready pattern", {24'd0, pat}, 32'h44);
      check("b2b first rdata", rd0, 32'hDE22BE44);
      check("b2b second rdata", rd1, 32'hFF000000);

      // Reset during the wait phase of a write to 0x8
      @(negedge PCLK);
      RegADDR   = 32'h08;
      RegWRITE  = 1'b1;
      RegWDATA  = 32'h55;
      RegSTRB   = 4'hF;
      RegENABLE = 1'b1;
      @(posedge PCLK);
      #1;
      RegENABLE = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(negedge PCLK);
      seen_ready = RegREADY;
      PRESETn = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge PCLK);
         seen_ready = seen_ready | RegREADY;
      end
      check("abort no ready", {31'd0, seen_ready}, 32'h0);
      txn(32'h08, 1'b0, 32'h0, 4'h0, rdy, err, rd, oth);
      check("abort read 0x8", rd, 32'h0);
      check("abort read 0x8 ready", {28'd0, rdy}, 32'h4);
      txn(32'h04, 1'b0, 32'h0, 4'h0, rdy, err, rd, oth);
      check("reset cleared 0x4", rd, 32'h0);

      // Randomized traffic against a register-array model
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
      for (int n = 0; n < 80; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 7)       a = 32'($urandom_range(0, 15) * 4);
         else if (sel == 7) a = 32'($urandom_range(0, 63));
         else if (sel == 8) a = 32'(64 + $urandom_range(0, 255));
         else               a = $urandom;
         w   = 1'($urandom_range(0, 1));
         wd  = $urandom;
         s   = 4'($urandom);
         idx = int'((a / 4) % 16);
         exp_err = (a % 4 != 0) || (a >= 64) || (w && idx == 0);
         if (!exp_err && w) begin
            for (int b = 0; b < 4; b++) begin
               if (s[b]) mdl[idx][b*8 +: 8] = wd[b*8 +: 8];
            end
         end
         if (!exp_err && !w) exp_rd = (idx == 0) ? 32'hA9B00001 : mdl[idx];
         else                exp_rd = 32'h0;
         txn(a, w, wd, s, rdy, err, rd, oth);
         check($sformatf("rnd%0d ready a=%h", n, a), {28'd0, rdy}, 32'h4);
         check($sformatf("rnd%0d slverr a=%h", n, a), {28'd0, err}, exp_err ? 32'h4 : 32'h0);
         check($sformatf("rnd%0d rdata a=%h", n, a), rd, exp_rd);
         check($sformatf("rnd%0d rdata_idle", n), {31'd0, oth}, 32'h0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_apb_reg_file
